// File: rtl/orion_pkg.sv
// ---------------------------------------------------------------------------
// orion_pkg
// Shared types and default sizes for the sequence RAM arbiter slice.
//   arb_state_t : arbiter FSM states (IDLE, GEN, GC)
//   owner_t     : which requester last released the RAM
//   *_DEF       : default address/data/depth/hold-limit sizes
// ---------------------------------------------------------------------------
package orion_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        GC   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_GEN = 1'b0,
        OWN_GC  = 1'b1
    } owner_t;

    localparam int ADDR_W_DEF   = 5;
    localparam int DATA_W_DEF   = 4;
    localparam int DEPTH_DEF    = 32;
    localparam int MAX_HOLD_DEF = 16;

endpackage : orion_pkg

// File: rtl/arb_hold_counter.sv
// ---------------------------------------------------------------------------
// arb_hold_counter
// Counts cycles the current owner has held the RAM grant. Saturates at
// MAX_HOLD-1 so an owner with no contender never wraps back to zero.
// Only instantiated when SEQ_ARB_STARVE_GUARD_EN is defined.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous reset, active low
//   clr      : restart the count (new grant or grant release)
//   inc      : one more owned cycle
//   at_limit : count has reached MAX_HOLD-1
// ---------------------------------------------------------------------------
module arb_hold_counter
    import orion_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam int              CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt_r;

    // Saturating hold counter: clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign at_limit = (cnt_r == LIMIT);

endmodule : arb_hold_counter

// File: rtl/seq_ram_arbiter.sv
// ---------------------------------------------------------------------------
// seq_ram_arbiter
// Shares the single-port sequence RAM between the digit sequencer (GEN,
// read/write) and the game controller (GC, read-only) with a req/grant
// handshake and round-robin tie breaking. Exactly one owner drives the RAM.
//
// Optional feature: define SEQ_ARB_STARVE_GUARD_EN to preempt an owner that
// has held the grant for MAX_HOLD cycles while the other side is waiting.
//
// Ports:
//   clk, rst                 : clock (rising) / async reset, active low
//   gen_req/we/addr/wdata    : sequencer request and access fields
//   gen_gnt                  : sequencer owns the RAM
//   gc_req/gc_addr           : controller read request and address
//   gc_gnt                   : controller owns the RAM
//   gc_rdata/gc_rvalid       : read result, valid pulse one cycle after issue
//   ram_en/we/addr/wdata     : RAM access port (combinational mux)
//   ram_rdata                : RAM read data, 1-cycle latency
//   busy                     : either requester owns the RAM
// ---------------------------------------------------------------------------
module seq_ram_arbiter
    import orion_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gen_req,
    input  logic              gen_we,
    input  logic [ADDR_W-1:0] gen_addr,
    input  logic [DATA_W-1:0] gen_wdata,
    output logic              gen_gnt,
    input  logic              gc_req,
    input  logic [ADDR_W-1:0] gc_addr,
    output logic              gc_gnt,
    output logic [DATA_W-1:0] gc_rdata,
    output logic              gc_rvalid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    // Elaboration-time parameter sanity.
    if (DEPTH > (1 << ADDR_W)) begin : g_depth_chk
        $error("seq_ram_arbiter: DEPTH exceeds address space");
    end
    if (MAX_HOLD < 2) begin : g_hold_chk
        $error("seq_ram_arbiter: MAX_HOLD must be at least 2");
    end

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    arb_state_t        state_r;
    owner_t            last_owner_r;
    logic              gen_gnt_r;
    logic              gc_gnt_r;
    logic              busy_r;
    logic              rd_pend_r;
    logic              rd_oor_r;
    logic [DATA_W-1:0] rdata_hold_r;

    logic gen_in_range_s;
    logic gc_in_range_s;
    logic owned_s;
    logic owner_req_s;
    logic other_req_s;
    logic preempt_s;
    logic release_s;
    logic gc_read_s;

    assign gen_in_range_s = ({1'b0, gen_addr} < DEPTH_L);
    assign gc_in_range_s  = ({1'b0, gc_addr} < DEPTH_L);
    assign owned_s        = gen_gnt_r | gc_gnt_r;
    assign gc_read_s      = gc_gnt_r & gc_req;

    // Request of the current owner and of the waiting side.
    always_comb begin
        owner_req_s = 1'b0;
        other_req_s = 1'b0;
        if (gen_gnt_r) begin
            owner_req_s = gen_req;
            other_req_s = gc_req;
        end else if (gc_gnt_r) begin
            owner_req_s = gc_req;
            other_req_s = gen_req;
        end else begin
            owner_req_s = 1'b0;
            other_req_s = 1'b0;
        end
    end

`ifdef SEQ_ARB_STARVE_GUARD_EN
    logic cnt_clr_s;
    logic cnt_inc_s;
    logic at_limit_s;

    // Count restarts whenever nobody owns the RAM or the grant is handed over.
    assign cnt_clr_s = ~owned_s | release_s;
    assign cnt_inc_s = owned_s & ~release_s;

    arb_hold_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr_s),
        .inc      (cnt_inc_s),
        .at_limit (at_limit_s)
    );

    assign preempt_s = at_limit_s & other_req_s;
`else
    assign preempt_s = 1'b0;
`endif

    // The owner gives up the RAM when it drops req or is preempted.
    assign release_s = owned_s & (~owner_req_s | preempt_s);

    // Arbiter FSM; grants and busy are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            last_owner_r <= OWN_GC;
            gen_gnt_r    <= 1'b0;
            gc_gnt_r     <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (gen_req && (!gc_req || (last_owner_r == OWN_GC))) begin
                        state_r   <= GEN;
                        gen_gnt_r <= 1'b1;
                        gc_gnt_r  <= 1'b0;
                        busy_r    <= 1'b1;
                    end else if (gc_req) begin
                        state_r   <= GC;
                        gen_gnt_r <= 1'b0;
                        gc_gnt_r  <= 1'b1;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                        gen_gnt_r <= 1'b0;
                        gc_gnt_r  <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                end
                GEN: begin
                    if (release_s) begin
                        last_owner_r <= OWN_GEN;
                        state_r      <= gc_req ? GC : IDLE;
                        gen_gnt_r    <= 1'b0;
                        gc_gnt_r     <= gc_req;
                        busy_r       <= gc_req;
                    end else begin
                        state_r   <= GEN;
                        gen_gnt_r <= 1'b1;
                        gc_gnt_r  <= 1'b0;
                        busy_r    <= 1'b1;
                    end
                end
                GC: begin
                    if (release_s) begin
                        last_owner_r <= OWN_GC;
                        state_r      <= gen_req ? GEN : IDLE;
                        gen_gnt_r    <= gen_req;
                        gc_gnt_r     <= 1'b0;
                        busy_r       <= gen_req;
                    end else begin
                        state_r   <= GC;
                        gen_gnt_r <= 1'b0;
                        gc_gnt_r  <= 1'b1;
                        busy_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    gen_gnt_r <= 1'b0;
                    gc_gnt_r  <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    // RAM port mux: only the owner reaches the RAM, GC can never write.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = {ADDR_W{1'b0}};
        ram_wdata = {DATA_W{1'b0}};
        if (gen_gnt_r) begin
            ram_en    = gen_req & gen_in_range_s;
            ram_we    = gen_req & gen_in_range_s & gen_we;
            ram_addr  = gen_addr;
            ram_wdata = gen_wdata;
        end else if (gc_gnt_r) begin
            ram_en    = gc_req & gc_in_range_s;
            ram_we    = 1'b0;
            ram_addr  = gc_addr;
            ram_wdata = {DATA_W{1'b0}};
        end else begin
            ram_en    = 1'b0;
            ram_we    = 1'b0;
            ram_addr  = {ADDR_W{1'b0}};
            ram_wdata = {DATA_W{1'b0}};
        end
    end

    // Read tracking: every issued GC read yields exactly one rvalid, even if
    // the grant is lost meanwhile. Out-of-range reads return zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend_r    <= 1'b0;
            rd_oor_r     <= 1'b0;
            rdata_hold_r <= {DATA_W{1'b0}};
        end else begin
            rd_pend_r <= gc_read_s;
            rd_oor_r  <= ~gc_in_range_s;
            if (rd_pend_r) begin
                rdata_hold_r <= rd_oor_r ? {DATA_W{1'b0}} : ram_rdata;
            end else begin
                rdata_hold_r <= rdata_hold_r;
            end
        end
    end

    // RAM data arrives in the rvalid cycle, so it is passed straight through
    // then and held from the register afterwards.
    always_comb begin
        gc_rdata = rdata_hold_r;
        if (rd_pend_r) begin
            gc_rdata = rd_oor_r ? {DATA_W{1'b0}} : ram_rdata;
        end else begin
            gc_rdata = rdata_hold_r;
        end
    end

    assign gc_rvalid = rd_pend_r;
    assign gen_gnt   = gen_gnt_r;
    assign gc_gnt    = gc_gnt_r;
    assign busy      = busy_r;

endmodule : seq_ram_arbiter

// File: tb/tb_seq_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seq_ram_arbiter
// Directed scenarios followed by random traffic. A behavioural model tracks
// the owner, round-robin history and expected RAM contents; issued GC reads
// push their expected digit into a queue that a monitor drains on rvalid.
// ---------------------------------------------------------------------------
module tb_seq_ram_arbiter;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 4;
    localparam int DEPTH    = 20;
    localparam int MAX_HOLD = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              gen_req = 1'b0;
    logic              gen_we = 1'b0;
    logic [ADDR_W-1:0] gen_addr = '0;
    logic [DATA_W-1:0] gen_wdata = '0;
    logic              gen_gnt;
    logic              gc_req = 1'b0;
    logic [ADDR_W-1:0] gc_addr = '0;
    logic              gc_gnt;
    logic [DATA_W-1:0] gc_rdata;
    logic              gc_rvalid;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic              busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk), .rst(rst),
        .gen_req(gen_req), .gen_we(gen_we), .gen_addr(gen_addr),
        .gen_wdata(gen_wdata), .gen_gnt(gen_gnt),
        .gc_req(gc_req), .gc_addr(gc_addr), .gc_gnt(gc_gnt),
        .gc_rdata(gc_rdata), .gc_rvalid(gc_rvalid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    // Synchronous single-port RAM attached to the arbiter
    logic [DATA_W-1:0] ram_mem [0:31];
    initial for (int i = 0; i < 32; i++) ram_mem[i] = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            ram_rdata <= ram_mem[ram_addr];
        end
    end

    // Reference model: owner 0=none, 1=gen, 2=gc
    int m_owner = 0;
    int m_last  = 2;
    int m_held  = 0;
    logic [DATA_W-1:0] m_mem [0:31];
    initial for (int i = 0; i < 32; i++) m_mem[i] = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner <= 0;
            m_last  <= 2;
            m_held  <= 0;
        end else begin : model_step
            int  nxt;
            bit  own_req, oth_req, give_up;
            if (m_owner == 1 && gen_req && gen_we && gen_addr < DEPTH)
                m_mem[gen_addr] <= gen_wdata;
            nxt = m_owner;
            if (m_owner == 0) begin
                if (gen_req && gc_req) nxt = (m_last == 1) ? 2 : 1;
                else if (gen_req)      nxt = 1;
                else if (gc_req)       nxt = 2;
            end else begin
                own_req = (m_owner == 1) ? gen_req : gc_req;
                oth_req = (m_owner == 1) ? gc_req : gen_req;
                give_up = !own_req;
`ifdef SEQ_ARB_STARVE_GUARD_EN
                // this cycle is owned cycle number m_held+1
                if (m_held + 1 >= MAX_HOLD && oth_req) give_up = 1'b1;
`endif
                if (give_up) begin
                    m_last <= m_owner;
                    nxt = oth_req ? (3 - m_owner) : 0;
                end
            end
            m_held  <= (nxt != 0 && nxt == m_owner) ? m_held + 1 : 0;
            m_owner <= nxt;
        end
    end

    logic [DATA_W-1:0] expq[$];
    logic [DATA_W-1:0] last_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every issued read must deliver rvalid exactly one cycle later
    always @(negedge clk) begin
        if (rst) begin
            chk("gc_rvalid", {31'd0, gc_rvalid}, {31'd0, expq.size() != 0});
            if (gc_rvalid && expq.size() != 0) begin
                last_rd = expq.pop_front();
                chk("gc_rdata", {28'd0, gc_rdata}, {28'd0, last_rd});
            end else if (!gc_rvalid) begin
                chk("rdata_hold", {28'd0, gc_rdata}, {28'd0, last_rd});
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gen_gnt"}, {31'd0, gen_gnt}, 32'd0);
        chk({tag, "_gc_gnt"}, {31'd0, gc_gnt}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rvalid"}, {31'd0, gc_rvalid}, 32'd0);
        chk({tag, "_rdata"}, {28'd0, gc_rdata}, 32'd0);
        chk({tag, "_ram_en"}, {31'd0, ram_en}, 32'd0);
        chk({tag, "_ram_we"}, {31'd0, ram_we}, 32'd0);
    endtask

    // One bus cycle: check registered grants, drive, check RAM mux, log reads
    task automatic cyc(input logic gr, input logic gw, input logic [4:0] ga,
                       input logic [3:0] gd, input logic cr, input logic [4:0] ca);
        bit exp_en, exp_we;
        @(negedge clk);
        chk("gen_gnt", {31'd0, gen_gnt}, {31'd0, m_owner == 1});
        chk("gc_gnt", {31'd0, gc_gnt}, {31'd0, m_owner == 2});
        chk("busy", {31'd0, busy}, {31'd0, m_owner != 0});
        gen_req = gr; gen_we = gw; gen_addr = ga; gen_wdata = gd;
        gc_req = cr; gc_addr = ca;
        #1;
        exp_en = (m_owner == 1 && gr && ga < DEPTH) || (m_owner == 2 && cr && ca < DEPTH);
        exp_we = (m_owner == 1 && gr && gw && ga < DEPTH);
        chk("ram_en", {31'd0, ram_en}, {31'd0, exp_en});
        chk("ram_we", {31'd0, ram_we}, {31'd0, exp_we});
        if (exp_en) chk("ram_addr", {27'd0, ram_addr}, {27'd0, (m_owner == 1) ? ga : ca});
        if (exp_we) chk("ram_wdata", {28'd0, ram_wdata}, {28'd0, gd});
        if (m_owner == 2 && cr) expq.push_back((ca < DEPTH) ? m_mem[ca] : 4'd0);
    endtask

    // Asynchronous reset right after an edge, while a read may be in flight
    task automatic mid_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk_all_zero("midrst");
        expq.delete();
        last_rd = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [3:0] seq [4] = '{4'd7, 4'd1, 4'd4, 4'd9};
    logic gr_r, cr_r;

    initial begin
        #1 chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // sequencer write burst 7,1,4,9 (first cycle waits for the grant)
        cyc(1, 1, 5'd0, seq[0], 0, 5'd0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 5'(i), seq[i], 0, 5'd0);
        cyc(0, 0, 5'd0, 4'd0, 0, 5'd0);
        cyc(0, 0, 5'd0, 4'd0, 0, 5'd0);
        // tie: last owner is GEN now, so GC should win; then hand back
        cyc(1, 0, 5'd0, 4'd0, 1, 5'd0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 5'd1, 4'd0, 1, 5'(i));
        // GC drops, GEN takes over with no dead cycle
        cyc(1, 0, 5'd2, 4'd0, 0, 5'd0);
        cyc(0, 0, 5'd2, 4'd0, 1, 5'd0);
        // back-to-back reads 0..3 then out-of-range 31
        for (int i = 0; i < 4; i++) cyc(0, 0, 5'd0, 4'd0, 1, 5'(i));
        cyc(0, 0, 5'd0, 4'd0, 1, 5'd31);
        cyc(0, 0, 5'd0, 4'd0, 1, 5'd19);
        cyc(0, 0, 5'd0, 4'd0, 1, 5'd20);
        // read then drop req: rvalid still expected
        cyc(0, 0, 5'd0, 4'd0, 0, 5'd0);
        cyc(0, 0, 5'd0, 4'd0, 0, 5'd0);
        // long GEN hold with GC waiting (preemption only with the guard)
        cyc(1, 0, 5'd3, 4'd0, 0, 5'd0);
        for (int i = 0; i < 8; i++) cyc(1, 1, 5'(10 + i), 4'(i + 3), 1, 5'd1);
        cyc(0, 0, 5'd0, 4'd0, 1, 5'd11);
        cyc(0, 0, 5'd0, 4'd0, 1, 5'd12);
        // reset mid-burst with a read in flight; first tie afterwards goes to GEN
        mid_reset();
        cyc(1, 0, 5'd0, 4'd0, 1, 5'd2);
        cyc(1, 0, 5'd0, 4'd0, 1, 5'd2);
        cyc(0, 0, 5'd0, 4'd0, 1, 5'd2);
        cyc(0, 0, 5'd0, 4'd0, 1, 5'd3);
        cyc(0, 0, 5'd0, 4'd0, 0, 5'd0);

        // random traffic with sticky requests
        gr_r = 1'b0;
        cr_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) gr_r = ~gr_r;
            if ($urandom_range(0, 3) == 0) cr_r = ~cr_r;
            cyc(gr_r, 1'($urandom), 5'($urandom_range(0, 31)), 4'($urandom),
                cr_r, 5'($urandom_range(0, 31)));
            if (i == 300) mid_reset();
        end
        cyc(0, 0, 5'd0, 4'd0, 0, 5'd0);
        cyc(0, 0, 5'd0, 4'd0, 0, 5'd0);
        @(negedge clk);
        #2 chk("queue_drained", expq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_ram_arbiter
